ps2_host_tx: RTL and testbench

Host-to-device PS/2 transmitter for the keyboard port; it is the counterpart of the existing PS2 receiver that produces `KB_Byte`. It sends one command byte to the keyboard, for example 0xED (set LEDs), 0xFF (reset) or 0xF4 (enable). Each transfer runs through the open-drain clock-inhibit / request-to-send sequence, then checks the device ACK and applies a watchdog. While `Busy` is high, the receiver ignores the shared lines.

---
 rtl/ps2_pkg.sv | 32 +++
 rtl/ps2_line_sync.sv | 36 +++
 rtl/ps2_host_tx.sv | 182 ++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter states, error codes
// and keyboard command bytes.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_RTS,
    ST_SEND,
    ST_WAIT_IDLE
  } tx_state_t;

  typedef enum logic [1:0] {
    ERR_OK      = 2'b00,
    ERR_NO_ACK  = 2'b01,
    ERR_TIMEOUT = 2'b10
  } tx_err_t;

  localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
  localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
  localparam logic [7:0] PS2_ACK_BYTE    = 8'hFA;

  // One counter serves inhibit, RTS and watchdog, so size it for the largest.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for the PS/2 clock and data pads,
// plus clock falling-edge detect.
module ps2_line_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic line_clk,
  input  logic line_data,
  output logic clk_sync,
  output logic data_sync,
  output logic clk_fall
);

  logic clk_meta;
  logic clk_prev;
  logic data_meta;

  // Idle bus level is high, so reset to 1 to avoid a phantom fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_meta  <= 1'b1;
      clk_sync  <= 1'b1;
      clk_prev  <= 1'b1;
      data_meta <= 1'b1;
      data_sync <= 1'b1;
    end else begin
      clk_meta  <= line_clk;
      clk_sync  <= clk_meta;
      clk_prev  <= clk_sync;
      data_meta <= line_data;
      data_sync <= data_meta;
    end
  end

  assign clk_fall = clk_prev & ~clk_sync;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter: inhibit, request-to-send,
// 11-bit frame clocked by the device, ACK check and watchdog.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int CLK_HZ         = 50_000_000,
  parameter int INHIBIT_CYCLES = CLK_HZ / 10_000,
  parameter int RTS_CYCLES     = CLK_HZ / 100_000,
  parameter int TIMEOUT_CYCLES = CLK_HZ / 1000 * 15
) (
  input  logic       Fast_Clock,
  input  logic       Raw_Reset_I,
  input  logic       Tx_Start,
  input  logic [7:0] Tx_Byte,
  input  logic       KB_Clk,
  input  logic       KB_Data,
  output logic       KB_Clk_Low,
  output logic       KB_Data_Low,
  output logic       Busy,
  output logic       Done,
  output logic [1:0] Tx_Err
);

  localparam int CW = cnt_width(INHIBIT_CYCLES, RTS_CYCLES, TIMEOUT_CYCLES);
  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] RTS_LAST = CW'(RTS_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);

  logic clk_sync;
  logic data_sync;
  logic clk_fall;

  ps2_line_sync u_sync (
    .clk       (Fast_Clock),
    .rst_n     (Raw_Reset_I),
    .line_clk  (KB_Clk),
    .line_data (KB_Data),
    .clk_sync  (clk_sync),
    .data_sync (data_sync),
    .clk_fall  (clk_fall)
  );

  tx_state_t     state_q, state_d;
  tx_err_t       err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    bit_q, bit_d;
  logic [8:0]    sh_q, sh_d;
  logic          clk_low_q, clk_low_d;
  logic          data_low_q, data_low_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          timeout;

  assign timeout = (cnt_q == TO_LAST);

  always_ff @(posedge Fast_Clock or negedge Raw_Reset_I) begin
    if (!Raw_Reset_I) begin
      state_q    <= ST_IDLE;
      err_q      <= ERR_OK;
      cnt_q      <= '0;
      bit_q      <= '0;
      sh_q       <= '0;
      clk_low_q  <= 1'b0;
      data_low_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      sh_q       <= sh_d;
      clk_low_q  <= clk_low_d;
      data_low_q <= data_low_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    sh_d       = sh_q;
    clk_low_d  = clk_low_q;
    data_low_d = data_low_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        clk_low_d  = 1'b0;
        data_low_d = 1'b0;
        busy_d     = 1'b0;
        if (Tx_Start) begin
          sh_d      = {~^Tx_Byte, Tx_Byte};
          cnt_d     = '0;
          bit_d     = '0;
          err_d     = ERR_OK;
          busy_d    = 1'b1;
          clk_low_d = 1'b1;
          state_d   = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        if (cnt_q == INH_LAST) begin
          cnt_d      = '0;
          data_low_d = 1'b1;
          state_d    = ST_RTS;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RTS: begin
        if (cnt_q == RTS_LAST) begin
          cnt_d     = '0;
          bit_d     = '0;
          clk_low_d = 1'b0;
          state_d   = ST_SEND;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_SEND: begin
        if (clk_fall) begin
          cnt_d = '0;
          bit_d = bit_q + 1'b1;
          if (bit_q <= 4'd8) begin
            // Data bits then parity leave LSB first.
            data_low_d = ~sh_q[0];
            sh_d       = {1'b0, sh_q[8:1]};
          end else if (bit_q == 4'd9) begin
            data_low_d = 1'b0;
          end else begin
            if (data_sync) err_d = ERR_NO_ACK;
            state_d = ST_WAIT_IDLE;
          end
        end else if (timeout) begin
          clk_low_d  = 1'b0;
          data_low_d = 1'b0;
          err_d      = ERR_TIMEOUT;
          done_d     = 1'b1;
          busy_d     = 1'b0;
          state_d    = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WAIT_IDLE: begin
        if (clk_sync && data_sync) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (clk_fall) begin
          cnt_d = '0;
        end else if (timeout) begin
          clk_low_d  = 1'b0;
          data_low_d = 1'b0;
          err_d      = ERR_TIMEOUT;
          done_d     = 1'b1;
          busy_d     = 1'b0;
          state_d    = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        clk_low_d  = 1'b0;
        data_low_d = 1'b0;
        busy_d     = 1'b0;
        state_d    = ST_IDLE;
      end
    endcase
  end

  assign KB_Clk_Low  = clk_low_q;
  assign KB_Data_Low = data_low_q;
  assign Busy        = busy_q;
  assign Done        = done_q;
  assign Tx_Err      = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus with a behavioural keyboard
// that clocks the frame, samples on rising edges and optionally ACKs.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH   = 20;
  localparam int RTSC  = 5;
  localparam int TO    = 400;
  localparam int H     = 8;
  localparam int LIMIT = 2000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_start = 1'b0;
  logic [7:0] tx_byte = 8'h00;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       kb_clk, kb_data;
  logic       clk_low, data_low, busy, done;
  logic [1:0] tx_err;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int last_fall_cyc = 0;
  int rise_cyc = 0;
  logic [1:0] done_err = 2'b00;
  bit done_lines_high = 1'b0;
  bit done_busy = 1'b0;
  bit done_outs = 1'b0;
  bit done_wide = 1'b0;
  bit done_prev = 1'b0;

  assign kb_clk  = dev_clk & ~clk_low;
  assign kb_data = dev_data & ~data_low;

  ps2_host_tx #(
    .CLK_HZ         (1_000_000),
    .INHIBIT_CYCLES (INH),
    .RTS_CYCLES     (RTSC),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .Fast_Clock  (clk),
    .Raw_Reset_I (rst_n),
    .Tx_Start    (tx_start),
    .Tx_Byte     (tx_byte),
    .KB_Clk      (kb_clk),
    .KB_Data     (kb_data),
    .KB_Clk_Low  (clk_low),
    .KB_Data_Low (data_low),
    .Busy        (busy),
    .Done        (done),
    .Tx_Err      (tx_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      done_cyc        = cyc;
      done_err        = tx_err;
      done_lines_high = kb_clk && kb_data;
      done_busy       = busy;
      done_outs       = clk_low || data_low;
    end
    if (done && done_prev) done_wide = 1'b1;
    done_prev = done;
  end

  // Expected frame as the keyboard sees it: start, LSB-first byte, odd parity, stop.
  function automatic logic [10:0] frame(input logic [7:0] b);
    int ones;
    logic par;
    ones = $countones(b);
    par  = (ones % 2 == 0) ? 1'b1 : 1'b0;
    return {1'b1, par, b, 1'b0};
  endfunction

  task automatic dev_xfer(input int nfalls, input bit ack,
                          output logic [10:0] rx, output bit ok);
    ok = 1'b0;
    rx = '1;
    for (int i = 0; i < LIMIT && !ok; i++) begin
      @(negedge clk);
      if (!clk_low && data_low) ok = 1'b1;
    end
    if (ok) begin
      repeat (4) @(posedge clk);
      #1;
      rx[0] = kb_data;
      for (int i = 1; i <= nfalls; i++) begin
        dev_clk = 1'b0;
        if (i == 11 && ack) dev_data = 1'b0;
        last_fall_cyc = cyc;
        repeat (H) @(posedge clk);
        #1;
        dev_clk  = 1'b1;
        rise_cyc = cyc;
        if (i <= 10) rx[i] = kb_data;
        repeat (H) @(posedge clk);
        #1;
      end
      dev_data = 1'b1;
    end
  endtask

  task automatic run_xfer(input logic [7:0] b, input int nfalls, input bit ack,
                          input bit inject, input bit want_done,
                          output logic [10:0] rx, output bit ok,
                          output bit got_done, output bit busy_rise);
    int d0;
    d0 = done_cnt;
    @(posedge clk);
    #1;
    tx_byte  = b;
    tx_start = 1'b1;
    @(posedge clk);
    #1;
    tx_start  = 1'b0;
    busy_rise = busy && clk_low && !data_low;
    if (inject) begin
      repeat (5) @(posedge clk);
      #1;
      tx_byte  = 8'h55;
      tx_start = 1'b1;
      @(posedge clk);
      #1;
      tx_start = 1'b0;
    end
    dev_xfer(nfalls, ack, rx, ok);
    got_done = 1'b0;
    if (want_done) begin
      for (int i = 0; i < LIMIT && !got_done; i++) begin
        @(negedge clk);
        if (done_cnt != d0) got_done = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({clk_low, data_low, busy, done, tx_err} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b want 000000",
               {clk_low, data_low, busy, done, tx_err});
    end
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (busy !== 1'b0 || clk_low !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_after_reset: busy %b clk_low %b want 0 0", busy, clk_low);
    end
  endtask

  task automatic test_send(input logic [7:0] b, input bit ack);
    logic [10:0] rx;
    bit ok, got, br;
    logic [1:0] want_err;
    want_err = ack ? 2'b00 : 2'b01;
    run_xfer(b, 11, ack, 1'b0, 1'b1, rx, ok, got, br);
    vectors++;
    if (!ok || !got) begin
      miscompares++;
      $display("FAIL handshake_%h: rts %b done %b want 1 1", b, ok, got);
    end
    vectors++;
    if (!br) begin
      miscompares++;
      $display("FAIL busy_rise_%h: got 0 want 1", b);
    end
    vectors++;
    if (rx !== frame(b)) begin
      miscompares++;
      $display("FAIL frame_%h: got %b want %b", b, rx, frame(b));
    end
    vectors++;
    if (done_err !== want_err || done_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL err_%h: err %b busy %b want %b 0", b, done_err, done_busy, want_err);
    end
    if (!ack) begin
      vectors++;
      if (!done_lines_high || done_cyc <= rise_cyc) begin
        miscompares++;
        $display("FAIL noack_idle_%h: lines_high %b done %0d rise %0d",
                 b, done_lines_high, done_cyc, rise_cyc);
      end
    end
  endtask

  task automatic test_parity();
    logic [7:0] bs [2];
    logic [10:0] rx;
    bit ok, got, br;
    bs[0] = 8'h01;
    bs[1] = PS2_CMD_RESET;
    for (int k = 0; k < 2; k++) begin
      run_xfer(bs[k], 11, 1'b1, 1'b0, 1'b1, rx, ok, got, br);
      vectors++;
      if (rx[9] !== ((k == 0) ? 1'b0 : 1'b1) || done_err !== 2'b00 || !got) begin
        miscompares++;
        $display("FAIL parity_%h: parity %b err %b done %b", bs[k], rx[9], done_err, got);
      end
    end
  endtask

  task automatic test_timeout();
    logic [10:0] rx;
    bit ok, got, br;
    logic [7:0] b;
    b = 8'($urandom);
    run_xfer(b, 4, 1'b0, 1'b0, 1'b1, rx, ok, got, br);
    vectors++;
    if (!got || done_err !== 2'b10) begin
      miscompares++;
      $display("FAIL timeout_err: done %b err %b want 1 10", got, done_err);
    end
    vectors++;
    if (done_cyc - last_fall_cyc != 3 + TO) begin
      miscompares++;
      $display("FAIL timeout_time: got %0d want %0d", done_cyc - last_fall_cyc, 3 + TO);
    end
    vectors++;
    if (done_outs !== 1'b0 || done_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_lines: outs %b busy %b want 0 0", done_outs, done_busy);
    end
  endtask

  task automatic test_ignore_busy();
    logic [10:0] rx;
    bit ok, got, br;
    int d0;
    d0 = done_cnt;
    run_xfer(PS2_CMD_SET_LED, 11, 1'b1, 1'b1, 1'b1, rx, ok, got, br);
    repeat (100) @(posedge clk);
    #1;
    vectors++;
    if (rx !== frame(PS2_CMD_SET_LED) || done_err !== 2'b00) begin
      miscompares++;
      $display("FAIL ignore_frame: got %b err %b want %b 00",
               rx, done_err, frame(PS2_CMD_SET_LED));
    end
    vectors++;
    if (done_cnt - d0 != 1 || busy !== 1'b0 || clk_low !== 1'b0) begin
      miscompares++;
      $display("FAIL ignore_extra: dones %0d busy %b clk_low %b want 1 0 0",
               done_cnt - d0, busy, clk_low);
    end
  endtask

  task automatic test_reset_abort();
    logic [10:0] rx;
    bit ok, got, br;
    logic [7:0] b;
    int d0;
    b = 8'($urandom);
    d0 = done_cnt;
    run_xfer(b, 4, 1'b0, 1'b0, 1'b0, rx, ok, got, br);
    vectors++;
    if (!ok || data_low !== ~b[3]) begin
      miscompares++;
      $display("FAIL abort_bit3: rts %b data_low %b want 1 %b", ok, data_low, ~b[3]);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({clk_low, data_low, busy} !== 3'b000) begin
      miscompares++;
      $display("FAIL abort_release: got %b want 000", {clk_low, data_low, busy});
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (TO + 50) @(posedge clk);
    #1;
    vectors++;
    if (done_cnt != d0) begin
      miscompares++;
      $display("FAIL abort_done: got %0d dones want 0", done_cnt - d0);
    end
    test_send(PS2_CMD_ENABLE, 1'b1);
  endtask

  task automatic test_random();
    for (int k = 0; k < 6; k++) begin
      test_send(8'($urandom), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_send(PS2_CMD_SET_LED, 1'b1);
    test_parity();
    test_send(8'h00, 1'b0);
    test_timeout();
    test_ignore_busy();
    test_reset_abort();
    test_random();
    vectors++;
    if (done_wide) begin
      miscompares++;
      $display("FAIL done_width: got >1 cycle want 1");
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
